// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control sequencer: FSM, NZCV flags register and condition check.
// Optional CTRL_PERF_COUNT_EN adds retired-instruction and memory-stall counters.
module arm_multicycle_controller #(
   parameter logic [3:0]  FLAG_RESET = 4'b0000,
   parameter int unsigned STATE_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [19:0]        instruction,
   input  logic [3:0]         ALUFlags,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUControl,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic [1:0]         RegSrc,
   output logic [3:0]         Flags,
`ifdef CTRL_PERF_COUNT_EN
   output logic [31:0]        InstrCount,
   output logic [31:0]        StallCount,
`endif
   output logic [STATE_W-1:0] State
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t state, next;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cmd;
   logic       i_bit, s_bit;

   assign cond  = instruction[19:16];
   assign op    = instruction[15:14];
   assign funct = instruction[13:8];
   assign rd    = instruction[3:0];
   assign i_bit = funct[5];
   assign cmd   = funct[4:1];
   assign s_bit = funct[0];

   // Data-processing command decode; invalid commands behave as NOPs.
   logic [1:0] alu_op;
   logic       cmd_valid, cmd_wr, cmd_cmp;
   always_comb begin
      alu_op    = 2'b00;
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
      cmd_cmp   = 1'b0;
      case (cmd)
         4'b0100: alu_op = 2'b00;
         4'b0010: alu_op = 2'b01;
         4'b0000: alu_op = 2'b10;
         4'b1100: alu_op = 2'b11;
         4'b1010: begin
            alu_op  = 2'b01;
            cmd_wr  = 1'b0;
            cmd_cmp = 1'b1;
         end
         default: begin
            cmd_valid = 1'b0;
            cmd_wr    = 1'b0;
         end
      endcase
   end

   logic n, z, c, v, cond_ex;
   assign {n, z, c, v} = Flags;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'h0: cond_ex = z;
         4'h1: cond_ex = !z;
         4'h2: cond_ex = c;
         4'h3: cond_ex = !c;
         4'h4: cond_ex = n;
         4'h5: cond_ex = !n;
         4'h6: cond_ex = v;
         4'h7: cond_ex = !v;
         4'h8: cond_ex = c && !z;
         4'h9: cond_ex = !c || z;
         4'hA: cond_ex = (n == v);
         4'hB: cond_ex = (n != v);
         4'hC: cond_ex = !z && (n == v);
         4'hD: cond_ex = z || (n != v);
         4'hE: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= next;
   end

   // Next state and per-state control outputs.
   always_comb begin
      next       = FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      case (state)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
            next      = MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (cond_ex) begin
               case (op)
                  2'b00:   next = i_bit ? EXECI : EXECR;
                  2'b01:   next = MEMADR;
                  2'b10:   next = BRANCH;
                  default: next = FETCH;
               endcase
            end
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
            ALUControl = alu_op;
            next       = cmd_wr ? ALUWB : FETCH;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            PCWrite  = (rd == 4'd15);
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            next    = s_bit ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            next   = MemReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            PCWrite   = (rd == 4'd15);
         end
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            next     = MemReady ? FETCH : MEMWR;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
         end
         default: next = FETCH;
      endcase
      // Strobes are held off while reset is asserted, even in FETCH.
      if (!reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign ImmSrc = op;
   assign RegSrc = {(op == 2'b01) && !s_bit, op == 2'b10};
   assign State  = STATE_W'(state);

   // Flags captured leaving EXECR/EXECI; logical ops only touch N and Z.
   logic flag_upd;
   assign flag_upd = ((state == EXECR) || (state == EXECI)) && cmd_valid && (s_bit || cmd_cmp);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Flags <= FLAG_RESET;
      end else if (flag_upd) begin
         if (!alu_op[1]) Flags      <= ALUFlags;
         else            Flags[3:2] <= ALUFlags[3:2];
      end
   end

`ifdef CTRL_PERF_COUNT_EN
   logic stall_cyc;
   assign stall_cyc = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !MemReady;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         InstrCount <= 32'd0;
         StallCount <= 32'd0;
      end else begin
         if ((state != FETCH) && (next == FETCH)) InstrCount <= InstrCount + 32'd1;
         if (stall_cyc)                           StallCount <= StallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench for arm_multicycle_controller: per-cycle expected outputs are
// queued with their stimulus, then popped and compared each cycle.
module tb_arm_multicycle_controller;

   localparam logic [3:0] S_FETCH = 4'd0, S_DEC = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3,
                          S_MWB = 4'd4, S_MWR = 4'd5, S_EXR = 4'd6, S_EXI = 4'd7,
                          S_AWB = 4'd8, S_BR = 4'd9;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] instruction;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0]  Flags;
   logic [3:0]  State;
`ifdef CTRL_PERF_COUNT_EN
   logic [31:0] InstrCount, StallCount;
`endif

   arm_multicycle_controller #(.FLAG_RESET(4'b0000), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .instruction(instruction), .ALUFlags(ALUFlags),
      .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
      .RegSrc(RegSrc), .Flags(Flags),
`ifdef CTRL_PERF_COUNT_EN
      .InstrCount(InstrCount), .StallCount(StallCount),
`endif
      .State(State)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] ins;
      logic        mr;
      logic [3:0]  af;
      logic [3:0]  st;
      logic        pcw, irw, memw, regw, adr;
      logic [1:0]  ctl, srcb, rsrc, rgs;
      logic [3:0]  fl;
   } cyc_t;

   cyc_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic [19:0] ins, input logic mr, input logic [3:0] af,
                       input logic [3:0] st, input logic pcw, input logic irw,
                       input logic memw, input logic regw, input logic adr,
                       input logic [1:0] ctl, input logic [1:0] srcb,
                       input logic [1:0] rsrc, input logic [1:0] rgs, input logic [3:0] fl);
      cyc_t e;
      e.ins = ins; e.mr = mr; e.af = af; e.st = st; e.pcw = pcw; e.irw = irw;
      e.memw = memw; e.regw = regw; e.adr = adr; e.ctl = ctl; e.srcb = srcb;
      e.rsrc = rsrc; e.rgs = rgs; e.fl = fl;
      sb.push_back(e);
   endtask

   // Drive each queued cycle just after posedge, compare at the following negedge.
   task automatic drain();
      cyc_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         instruction = e.ins;
         MemReady    = e.mr;
         ALUFlags    = e.af;
         @(negedge clk);
         check("state",      32'(State),      32'(e.st));
         check("pcwrite",    32'(PCWrite),    32'(e.pcw));
         check("irwrite",    32'(IRWrite),    32'(e.irw));
         check("memwrite",   32'(MemWrite),   32'(e.memw));
         check("regwrite",   32'(RegWrite),   32'(e.regw));
         check("adrsrc",     32'(AdrSrc),     32'(e.adr));
         check("alucontrol", 32'(ALUControl), 32'(e.ctl));
         check("alusrcb",    32'(ALUSrcB),    32'(e.srcb));
         check("resultsrc",  32'(ResultSrc),  32'(e.rsrc));
         check("regsrc",     32'(RegSrc),     32'(e.rgs));
         check("flags",      32'(Flags),      32'(e.fl));
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [19:0] I_ADD  = 20'hE0812;  // ADD R2,R1,R3
   localparam logic [19:0] I_BEQ  = 20'h0A000;
   localparam logic [19:0] I_CMP  = 20'hE3510;  // CMP R1,#5
   localparam logic [19:0] I_ORRS = 20'hE391F;  // ORRS PC,R1,#imm
   localparam logic [19:0] I_LDR  = 20'hE5912;
   localparam logic [19:0] I_STR  = 20'hE5812;

   task automatic push_add(input logic first_stalls);
      if (first_stalls) begin
         push(I_ADD, 0, 4'h0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0);
         push(I_ADD, 0, 4'h0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0);
      end
      push(I_ADD, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0);
      push(I_ADD, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h0);
      push(I_ADD, 1, 4'hF, S_EXR,   0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0);
      push(I_ADD, 1, 4'hF, S_AWB,   0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0);
   endtask

   initial begin
      reset       = 1'b0;
      MemReady    = 1'b1;
      ALUFlags    = 4'h0;
      instruction = I_ADD;
      #2;
      check("rst_state", 32'(State), 32'(S_FETCH));
      check("rst_flags", 32'(Flags), 32'h0);
      check("rst_pcwrite", 32'(PCWrite), 32'h0);
      check("rst_irwrite", 32'(IRWrite), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // ADD with S=0: flags must ignore ALUFlags=F during EXECR.
      push_add(1'b0);
      // BEQ with Z=0: condition fails, two cycles.
      push(I_BEQ, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b01, 4'h0);
      push(I_BEQ, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 4'h0);
      // CMP #5 sets Z.
      push(I_CMP, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h0);
      push(I_CMP, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h0);
      push(I_CMP, 1, 4'h4, S_EXI,   0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 4'h0);
      // BEQ now taken.
      push(I_BEQ, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b01, 4'h4);
      push(I_BEQ, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 4'h4);
      push(I_BEQ, 1, 4'h0, S_BR,    1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b01, 4'h4);
      // ORRS to PC: only N,Z taken from ALUFlags=1011; C,V kept from 0100.
      push(I_ORRS, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h4);
      push(I_ORRS, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h4);
      push(I_ORRS, 1, 4'hB, S_EXI,   0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 4'h4);
      push(I_ORRS, 1, 4'h0, S_AWB,   1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8);
      // LDR with one FETCH stall and three MEMRD stalls.
      push(I_LDR, 0, 4'h0, S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h8);
      push(I_LDR, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 4'h8);
      push(I_LDR, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'h8);
      push(I_LDR, 1, 4'h0, S_MADR,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 4'h8);
      for (int k = 0; k < 3; k++)
         push(I_LDR, 0, 4'h0, S_MRD, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8);
      push(I_LDR, 1, 4'h0, S_MRD,   0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8);
      push(I_LDR, 1, 4'h0, S_MWB,   0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4'h8);
      // STR held in MEMWR, then aborted by reset.
      push(I_STR, 1, 4'h0, S_FETCH, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 4'h8);
      push(I_STR, 1, 4'h0, S_DEC,   0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'h8);
      push(I_STR, 1, 4'h0, S_MADR,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 4'h8);
      push(I_STR, 0, 4'h0, S_MWR,   0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 4'h8);
      push(I_STR, 0, 4'h0, S_MWR,   0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 4'h8);
      drain();

      check("str_immsrc", 32'(ImmSrc), 32'h1);
      check("str_memwrite_pre", 32'(MemWrite), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("abort_memwrite", 32'(MemWrite), 32'h0);
      check("abort_state", 32'(State), 32'(S_FETCH));
      check("abort_flags", 32'(Flags), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Three ADDs, the first with two FETCH stall cycles.
      push_add(1'b1);
      push_add(1'b0);
      push_add(1'b0);
      drain();
      check("post_state", 32'(State), 32'(S_FETCH));
`ifdef CTRL_PERF_COUNT_EN
      check("instr_count", InstrCount, 32'd3);
      check("stall_count", StallCount, 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arm_multicycle_controller.md
Name: arm_multicycle_controller

Overview:
Multicycle ARM control sequencer. Replaces the single-cycle control path with an FSM that steps one shared ALU/memory datapath through fetch, decode, execute, memory and writeback. Holds the NZCV flags register and the condition-check logic. Stalls on a memory-ready handshake.

Parameters:
FLAG_RESET, 4'b0000, reset value of the NZCV flags register
STATE_W, 4, width of state encoding and of debug State port

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
instruction  in  20  instr[31:12] from the IR: Cond[31:28], OpCode[27:26], Funct[25:20], Rd[15:12]
ALUFlags  in  4  NZCV from the ALU, current cycle
MemReady  in  1  memory has completed the current access
PCWrite  out  1  load PC
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24
RegWrite  out  1  register file write
RegSrc  out  2  bit0: RA1=PC(15) for branch; bit1: RA2=Rd for STR
Flags  out  4  current NZCV register
State  out  STATE_W  current state (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, Flags=FLAG_RESET. All strobes (PCWrite, MemWrite, IRWrite, RegWrite) =0. Other outputs take FETCH values.
- Decode fields: I=Funct[5], cmd=Funct[4:1], S/L=Funct[0].
- cmd map: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 CMP→SUB with no register write. Any other cmd is a NOP: return to FETCH, no writes.
- ImmSrc = OpCode, combinational in every state.
- RegSrc = {OpCode==01 && !L, OpCode==10}, combinational.
- CondEx from the registered Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL (1110) =1; 1111 =0
- States and outputs (unlisted strobes are 0):
  - FETCH: AdrSrc0, ALUSrcA1, ALUSrcB10, ADD, ResultSrc10. IRWrite=PCWrite=MemReady. Holds until MemReady=1, then DECODE.
  - DECODE: ALUSrcA1, ALUSrcB10, ADD (PC+8 on RD path). If !CondEx, go to FETCH. Otherwise: OpCode 00 → EXECR (I=0) or EXECI (I=1); 01 → MEMADR; 10 → BRANCH; 11 → FETCH.
  - EXECR: ALUSrcA0, ALUSrcB00, ALU op from cmd. Next ALUWB, or FETCH for CMP/NOP.
  - EXECI: same as EXECR with ALUSrcB01.
  - ALUWB: ResultSrc00, RegWrite=1. If Rd==15, PCWrite=1 too. Next FETCH.
  - MEMADR: ALUSrcA0, ALUSrcB01, ADD (U-bit ignored). Next MEMRD if L=1, else MEMWR.
  - MEMRD: AdrSrc1. Holds until MemReady, then MEMWB.
  - MEMWB: ResultSrc01, RegWrite=1; if Rd==15, PCWrite=1. Next FETCH.
  - MEMWR: AdrSrc1, MemWrite=1 every cycle until MemReady. Next FETCH.
  - BRANCH: ALUSrcA0, ALUSrcB01, ADD, ResultSrc10, PCWrite=1. Next FETCH.
- Flags update: on the clock edge leaving EXECR/EXECI when S=1.
  - ADD/SUB/CMP write all NZCV from ALUFlags.
  - AND/ORR write N,Z only.
  - CMP always updates flags.
  - Flags are never updated in any other state.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3, cond-fail 2, assuming MemReady=1. Each MemReady=0 cycle adds one.
- Reset asserted mid-instruction aborts immediately to FETCH; no partial write completes after reset.
- Illegal state encodings go to FETCH.

Optional Feature:
CTRL_PERF_COUNT_EN:
- Defined: adds outputs InstrCount[31:0] and StallCount[31:0], both reset to 0.
  - InstrCount increments on every transition into FETCH from a non-FETCH state, including cond-fail.
  - StallCount increments on every cycle in FETCH/MEMRD/MEMWR with MemReady=0.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with MemReady=1, then instr E0812003 (ADD R2,R1,R3): states FETCH,DECODE,EXECR,ALUWB. ALUControl=00 in EXECR, RegWrite=1 only in ALUWB, Flags unchanged.
- E3510005 (CMP R1,#5) with ALUFlags=0100: path FETCH,DECODE,EXECI,FETCH. RegWrite never 1, Flags=0100 after EXECI.
- With Flags Z=0, instr 0A000002 (BEQ): DECODE→FETCH, PCWrite only in FETCH, 2-cycle instruction.
- E5912004 (LDR) with MemReady held 0 for 3 cycles in MEMRD: state stays MEMRD 4 cycles, then MEMWB with RegWrite=1, ResultSrc=01.
- E5812000 (STR) with reset deasserted→asserted in MEMWR: MemWrite drops asynchronously to 0, State=FETCH, Flags=FLAG_RESET.
- With CTRL_PERF_COUNT_EN defined, run 3 instructions with 2 FETCH stall cycles: InstrCount=3, StallCount=2.
